dtw_stream_io: RTL and testbench
================================

// Module: dtw_stream_io
// PURPOSE
//  Host-side companion to the DTW core: frames an incoming 32-bit stream into the core's src FIFO and drains
//  the core's sink FIFO into parallel result records. Ingress sequences the core start handshake
//  (rs/busy/src_fifo_clear), then writes ref_len reference words (op_mode=1) or 1 qid + SQG_SIZE samples (op_mode=0).
//  Egress reads 3-word records (qid, position, minval) and presents them on a valid/ready port.
// PARAMETERS
//  AXIS_WIDTH     32   stream/FIFO word width
//  WIDTH          16   minval width (low bits of result word 2)
//  SQG_SIZE       250  query samples per frame (after the qid word)
//  START_TIMEOUT  4    cycles after rs to wait for busy=1 before rejecting the frame
// PORTS
//  clk             in   1   clock
//  rst_n           in   1   asynchronous active-low reset
//  op_mode         in   1   frame type, sampled at frame start: 1=reference load, 0=query
//  ref_len         in   32  reference length in words, sampled at frame start
//  s_tdata         in   32  ingress word
//  s_tvalid        in   1   ingress valid
//  s_tlast         in   1   last word of host frame
//  s_tready        out  1   ingress ready
//  rs              out  1   core start pulse
//  busy            in   1   core busy
//  load_done       in   1   core reference-loaded flag
//  src_fifo_clear  in   1   core is holding the src FIFO in clear
//  src_fifo_wren   out  1   src FIFO write enable
//  src_fifo_data   out  32  src FIFO write data
//  src_fifo_full   in   1   src FIFO full
//  sink_fifo_rden  out  1   sink FIFO read enable (data valid the cycle after rden)
//  sink_fifo_empty in   1   sink FIFO empty
//  sink_fifo_data  in   32  sink FIFO read data
//  m_qid           out  32  result query id
//  m_position      out  32  result best position
//  m_minval        out  16  result minimum DTW cost
//  m_valid         out  1   result valid
//  m_ready         in   1   result accepted
//  err_short, err_long, err_rej  out 1 each  sticky framing errors
//  err_clr         in   1   clears all sticky errors
//  frames_done     out  16  count of completed frames, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset: all outputs 0; ingress in I_IDLE, egress in E_IDLE; counters 0.
//  Ingress FSM:
//   I_IDLE: s_tready=0. When s_tvalid=1, latch op_mode/ref_len, set need = ref_len (mode 1) or SQG_SIZE+1 (mode 0),
//    drive rs=1 for exactly one cycle, go to I_START.
//   I_START: wait for busy=1 && src_fifo_clear=0, then go to I_STREAM. If START_TIMEOUT cycles pass without busy,
//    the core declined the frame (mode 1 with load_done=1, or mode 0 with load_done=0): set err_rej, go to I_DROP.
//   I_STREAM: s_tready = !src_fifo_full. A write occurs on s_tvalid&&s_tready: src_fifo_wren=1, data=s_tdata
//    (same cycle, no register stage), cnt++.
//    - Write with cnt==need-1 and s_tlast=1: go to I_WAIT.
//    - Write with cnt==need-1 and s_tlast=0: set err_long, go to I_DROP.
//    - Write with s_tlast=1 and cnt<need-1: set err_short, go to I_PAD.
//   I_PAD: s_tready=0; write 32'h0 each cycle src_fifo_full=0 until cnt==need, then go to I_WAIT.
//   I_DROP: s_tready=1; discard words; on s_tvalid&&s_tlast go to I_WAIT (rejected frame: back to I_IDLE).
//   I_WAIT: s_tready=0; wait for busy=0. Mode 0 also waits for the egress record to be accepted.
//    Then frames_done++, go to I_IDLE.
//  src_fifo_wren is never asserted while src_fifo_clear=1 or src_fifo_full=1.
//  Egress FSM:
//   E_IDLE: drive sink_fifo_rden=1 for one cycle when !sink_fifo_empty, go to E_CAP.
//   E_CAP: capture sink_fifo_data into word[k] with k=0,1,2. Word 0 -> m_qid, word 1 -> m_position,
//    word 2[WIDTH-1:0] -> m_minval; upper bits are ignored. After k=2 go to E_OUT, otherwise go to E_IDLE.
//   E_OUT: m_valid=1 with data held stable until m_ready=1, then m_valid=0 the next cycle.
//    No sink reads occur while m_valid=1.
//  Errors: sticky until err_clr. If a set and err_clr occur in the same cycle, the set wins.
//  rst_n deassert/assert mid-frame: immediate return to reset state. The partial FIFO content is discarded by the
//   core's clear on its next IDLE.
// TESTING
//  1 ref load: op_mode=1, ref_len=8, 8 words with tlast on word 8 -> rs pulse once, 8 src writes in order,
//    frames_done=1, no errors.
//  2 query: op_mode=0, SQG_SIZE=4, words {0x55,1,2,3,4}; sink supplies {0x55,0x1234,0xABCD0042}
//    -> m_qid=0x55, m_position=0x1234, m_minval=0x0042.
//  3 short frame: SQG_SIZE=4, tlast on word 3 -> err_short=1, 2 zero pad words written, 5 src writes total.
//  4 reject: load_done=1 with op_mode=1 and busy stuck 0 -> err_rej after 4 cycles, frame dropped, 0 src writes.
//  5 backpressure: src_fifo_full toggling every other cycle, m_ready held 0 for 10 cycles
//    -> no write while full, m_* stable, no sink_fifo_rden while m_valid.
//  6 reset mid-stream: rst_n=0 at word 3 -> all outputs 0 immediately; next frame runs cleanly.

Source files
------------

// File: rtl/dtw_stream_io.sv
// Host-side stream framer for the DTW core: feeds the src FIFO from a 32-bit ingress stream
// and assembles 3-word result records from the sink FIFO onto a valid/ready port.
module dtw_stream_io #(
  parameter int AXIS_WIDTH    = 32,
  parameter int WIDTH         = 16,
  parameter int SQG_SIZE      = 250,
  parameter int START_TIMEOUT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  op_mode,
  input  logic [31:0]           ref_len,
  input  logic [AXIS_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  input  logic                  s_tlast,
  output logic                  s_tready,
  output logic                  rs,
  input  logic                  busy,
  input  logic                  load_done,
  input  logic                  src_fifo_clear,
  output logic                  src_fifo_wren,
  output logic [AXIS_WIDTH-1:0] src_fifo_data,
  input  logic                  src_fifo_full,
  output logic                  sink_fifo_rden,
  input  logic                  sink_fifo_empty,
  input  logic [AXIS_WIDTH-1:0] sink_fifo_data,
  output logic [AXIS_WIDTH-1:0] m_qid,
  output logic [AXIS_WIDTH-1:0] m_position,
  output logic [WIDTH-1:0]      m_minval,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  err_short,
  output logic                  err_long,
  output logic                  err_rej,
  input  logic                  err_clr,
  output logic [15:0]           frames_done
);

  localparam int          TW       = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(START_TIMEOUT - 1);
  localparam logic [31:0] NEED_Q   = 32'(SQG_SIZE + 1);

  typedef enum logic [2:0] {I_IDLE, I_START, I_STREAM, I_PAD, I_DROP, I_WAIT} istate_t;
  typedef enum logic [1:0] {E_IDLE, E_CAP, E_OUT} estate_t;

  istate_t r_ist, w_ist_nxt;
  estate_t r_est, w_est_nxt;

  logic          r_mode;
  logic [31:0]   r_need;
  logic [31:0]   r_cnt;
  logic [TW-1:0] r_tmo;
  logic          r_rej;
  logic          r_rs;
  logic          r_err_short, r_err_long, r_err_rej;
  logic [15:0]   r_frames;
  logic          r_rec_done;
  logic [1:0]    r_k;
  logic [AXIS_WIDTH-1:0] r_qid, r_pos;
  logic [WIDTH-1:0]      r_minval;

  logic                  w_tready, w_wren, w_start, w_fdone;
  logic                  w_set_short, w_set_long, w_set_rej;
  logic [AXIS_WIDTH-1:0] w_wdata;
  logic                  w_last, w_pad_done, w_fifo_ok;
  logic                  w_rden, w_acc;

  // w_last: the word being written now completes the frame
  assign w_last     = ({1'b0, r_cnt} + 33'd1) >= {1'b0, r_need};
  assign w_pad_done = r_cnt >= r_need;
  assign w_fifo_ok  = !src_fifo_full && !src_fifo_clear;
  assign w_acc      = (r_est == E_OUT) && m_ready;

  always_comb begin
    w_ist_nxt   = r_ist;
    w_tready    = 1'b0;
    w_wren      = 1'b0;
    w_wdata     = '0;
    w_start     = 1'b0;
    w_fdone     = 1'b0;
    w_set_short = 1'b0;
    w_set_long  = 1'b0;
    w_set_rej   = 1'b0;
    case (r_ist)
      I_IDLE: begin
        if (s_tvalid) begin
          w_start   = 1'b1;
          w_ist_nxt = I_START;
        end
      end
      I_START: begin
        if (busy && !src_fifo_clear) begin
          w_ist_nxt = I_STREAM;
        end else if (!busy && r_tmo == TMO_LAST) begin
          w_set_rej = 1'b1;
          w_ist_nxt = I_DROP;
        end
      end
      I_STREAM: begin
        w_tready = w_fifo_ok;
        if (s_tvalid && w_fifo_ok) begin
          w_wren  = 1'b1;
          w_wdata = s_tdata;
          if (w_last) begin
            if (s_tlast) begin
              w_ist_nxt = I_WAIT;
            end else begin
              w_set_long = 1'b1;
              w_ist_nxt  = I_DROP;
            end
          end else if (s_tlast) begin
            w_set_short = 1'b1;
            w_ist_nxt   = I_PAD;
          end
        end
      end
      I_PAD: begin
        if (w_pad_done) begin
          w_ist_nxt = I_WAIT;
        end else if (w_fifo_ok) begin
          w_wren = 1'b1;
          if (w_last) w_ist_nxt = I_WAIT;
        end
      end
      I_DROP: begin
        w_tready = 1'b1;
        if (s_tvalid && s_tlast) w_ist_nxt = r_rej ? I_IDLE : I_WAIT;
      end
      I_WAIT: begin
        // queries also hold until the host has taken the result record
        if (!busy && (r_mode || r_rec_done)) begin
          w_fdone   = 1'b1;
          w_ist_nxt = I_IDLE;
        end
      end
      default: w_ist_nxt = I_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ist    <= I_IDLE;
      r_mode   <= 1'b0;
      r_need   <= '0;
      r_cnt    <= '0;
      r_tmo    <= '0;
      r_rej    <= 1'b0;
      r_rs     <= 1'b0;
      r_frames <= '0;
    end else begin
      r_ist <= w_ist_nxt;
      r_rs  <= w_start;
      if (w_start) begin
        r_mode <= op_mode;
        r_need <= op_mode ? ref_len : NEED_Q;
        r_rej  <= 1'b0;
      end
      if (w_start)     r_cnt <= '0;
      else if (w_wren) r_cnt <= r_cnt + 32'd1;
      if (r_ist != I_START)      r_tmo <= '0;
      else if (r_tmo != TMO_LAST) r_tmo <= r_tmo + 1'b1;
      if (w_set_rej) r_rej <= 1'b1;
      if (w_fdone)   r_frames <= r_frames + 16'd1;
    end
  end

  // sticky errors: a set in the same cycle as err_clr wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_short <= 1'b0;
      r_err_long  <= 1'b0;
      r_err_rej   <= 1'b0;
    end else begin
      r_err_short <= w_set_short | (r_err_short & ~err_clr);
      r_err_long  <= w_set_long  | (r_err_long  & ~err_clr);
      r_err_rej   <= w_set_rej   | (r_err_rej   & ~err_clr);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_rec_done <= 1'b0;
    else if (w_acc)   r_rec_done <= 1'b1;
    else if (w_start) r_rec_done <= 1'b0;
  end

  always_comb begin
    w_est_nxt = r_est;
    w_rden    = 1'b0;
    case (r_est)
      E_IDLE: begin
        if (!sink_fifo_empty) begin
          w_rden    = 1'b1;
          w_est_nxt = E_CAP;
        end
      end
      E_CAP:   w_est_nxt = (r_k == 2'd2) ? E_OUT : E_IDLE;
      E_OUT:   if (m_ready) w_est_nxt = E_IDLE;
      default: w_est_nxt = E_IDLE;
    endcase
  end

  // sink data is valid the cycle after rden, i.e. while in E_CAP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_est    <= E_IDLE;
      r_k      <= '0;
      r_qid    <= '0;
      r_pos    <= '0;
      r_minval <= '0;
    end else begin
      r_est <= w_est_nxt;
      if (r_est == E_CAP) begin
        case (r_k)
          2'd0:    r_qid    <= sink_fifo_data;
          2'd1:    r_pos    <= sink_fifo_data;
          default: r_minval <= sink_fifo_data[WIDTH-1:0];
        endcase
        r_k <= (r_k == 2'd2) ? 2'd0 : r_k + 2'd1;
      end
    end
  end

  assign s_tready       = w_tready;
  assign rs             = r_rs;
  assign src_fifo_wren  = w_wren;
  assign src_fifo_data  = w_wdata;
  assign sink_fifo_rden = w_rden;
  assign m_qid          = r_qid;
  assign m_position     = r_pos;
  assign m_minval       = r_minval;
  assign m_valid        = (r_est == E_OUT);
  assign err_short      = r_err_short;
  assign err_long       = r_err_long;
  assign err_rej        = r_err_rej;
  assign frames_done    = r_frames;

endmodule

// File: tb/tb_dtw_stream_io.sv
// Directed bench for dtw_stream_io with a tiny core/sink-FIFO model and hand-computed expectations.
module tb_dtw_stream_io;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        op_mode = 1'b0, s_tvalid = 1'b0, s_tlast = 1'b0, load_done = 1'b0;
  logic [31:0] ref_len = '0, s_tdata = '0;
  logic        src_fifo_full = 1'b0, m_ready = 1'b0, err_clr = 1'b0;
  logic        busy, src_fifo_clear, sink_fifo_empty;
  logic [31:0] sink_fifo_data;
  logic        s_tready, rs, src_fifo_wren, sink_fifo_rden, m_valid;
  logic [31:0] src_fifo_data, m_qid, m_position;
  logic [15:0] m_minval, frames_done;
  logic        err_short, err_long, err_rej;

  logic core_accept = 1'b1, core_release = 1'b0, toggle_full = 1'b0;
  int   total = 0, bad = 0;

  always #5 clk = ~clk;

  dtw_stream_io #(.AXIS_WIDTH(32), .WIDTH(16), .SQG_SIZE(4), .START_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .op_mode(op_mode), .ref_len(ref_len),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .rs(rs), .busy(busy), .load_done(load_done), .src_fifo_clear(src_fifo_clear),
    .src_fifo_wren(src_fifo_wren), .src_fifo_data(src_fifo_data), .src_fifo_full(src_fifo_full),
    .sink_fifo_rden(sink_fifo_rden), .sink_fifo_empty(sink_fifo_empty), .sink_fifo_data(sink_fifo_data),
    .m_qid(m_qid), .m_position(m_position), .m_minval(m_minval), .m_valid(m_valid), .m_ready(m_ready),
    .err_short(err_short), .err_long(err_long), .err_rej(err_rej), .err_clr(err_clr),
    .frames_done(frames_done)
  );

  // core: accepts on rs by raising busy, holds src clear for one cycle
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy           <= 1'b0;
      src_fifo_clear <= 1'b0;
    end else begin
      src_fifo_clear <= rs && core_accept;
      if (rs && core_accept) busy <= 1'b1;
      else if (core_release) busy <= 1'b0;
    end
  end

  logic [31:0] sink_mem [16];
  int sink_wp = 0, sink_rp = 0;
  assign sink_fifo_empty = (sink_rp == sink_wp);
  always @(posedge clk) begin
    if (sink_fifo_rden && sink_rp != sink_wp) begin
      sink_fifo_data <= sink_mem[sink_rp[3:0]];
      sink_rp        <= sink_rp + 1;
    end
  end

  int cyc = 0, nw = 0, nrs = 0, nrej = 0, viol = 0, rs_cyc = 0, rej_cyc = 0;
  logic [31:0] wq [64];
  logic        prev_rej = 1'b0, hold_q = 1'b0;
  logic [79:0] snap = '0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n) begin
      if (src_fifo_wren) begin
        wq[nw[5:0]] <= src_fifo_data;
        nw          <= nw + 1;
      end
      viol <= viol + ((src_fifo_wren && (src_fifo_full || src_fifo_clear)) ? 1 : 0)
                   + ((sink_fifo_rden && m_valid) ? 1 : 0)
                   + ((hold_q && (!m_valid || {m_qid, m_position, m_minval} != snap)) ? 1 : 0);
      hold_q <= m_valid && !m_ready;
      snap   <= {m_qid, m_position, m_minval};
      if (rs) begin
        nrs    <= nrs + 1;
        rs_cyc <= cyc;
      end
      if (err_rej && !prev_rej) begin
        nrej    <= nrej + 1;
        rej_cyc <= cyc;
      end
      prev_rej <= err_rej;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    int n = 0;
    logic rdy = 1'b0;
    while (!rdy && n < 200) begin
      @(negedge clk);
      if (toggle_full) src_fifo_full = ~src_fifo_full;
      s_tvalid = 1'b1; s_tdata = d; s_tlast = last;
      #1 rdy = s_tready;
      n++;
    end
    if (!rdy) chk("send_timeout", 32'(rdy), 32'd1);
  endtask

  task automatic idle();
    @(negedge clk);
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic release_core();
    @(negedge clk) core_release = 1'b1;
    @(negedge clk) core_release = 1'b0;
  endtask

  task automatic push_sink(input logic [31:0] w);
    sink_mem[sink_wp[3:0]] = w;
    sink_wp++;
  endtask

  task automatic wait_frames(input logic [15:0] exp);
    int n = 0;
    while (frames_done != exp && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("frames_done", 32'(frames_done), 32'(exp));
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!m_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("m_valid_wait", 32'(m_valid), 32'd1);
  endtask

  task automatic accept();
    @(negedge clk) m_ready = 1'b1;
    @(negedge clk) m_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, r0, q0;
    repeat (3) @(negedge clk);
    chk("rst_outs", {rs, src_fifo_wren, s_tready, sink_fifo_rden, m_valid, err_short, err_long, err_rej}, 0);
    chk("rst_frames", 32'(frames_done), 0);
    chk("rst_qid", m_qid, 0);
    rst_n = 1'b1;

    // 1: reference load of 8 words; mode/len changed mid-frame must not matter
    op_mode = 1'b1; ref_len = 8; base = nw; r0 = nrs;
    for (int i = 0; i < 8; i++) begin
      send(32'h100 + 32'(i), i == 7);
      if (i == 0) begin op_mode = 1'b0; ref_len = 0; end
    end
    idle(); release_core(); wait_frames(1);
    chk("t1_rs", 32'(nrs - r0), 1);
    chk("t1_nw", 32'(nw - base), 8);
    for (int i = 0; i < 8; i++) chk("t1_word", wq[base + i], 32'h100 + 32'(i));
    chk("t1_err", {err_short, err_long, err_rej}, 0);

    // 2: query of qid + 4 samples, record back from sink
    op_mode = 1'b0; base = nw;
    send(32'h55, 0); send(1, 0); send(2, 0); send(3, 0); send(4, 1); idle();
    push_sink(32'h55); push_sink(32'h1234); push_sink(32'hABCD0042);
    release_core(); wait_valid();
    chk("t2_qid", m_qid, 32'h55);
    chk("t2_pos", m_position, 32'h1234);
    chk("t2_min", 32'(m_minval), 32'h42);
    repeat (3) @(negedge clk);
    chk("t2_hold_frames", 32'(frames_done), 1);
    accept(); wait_frames(2);
    chk("t2_nw", 32'(nw - base), 5);
    chk("t2_w4", wq[base + 4], 4);

    // 3: short query, tlast on third word -> two zero pads
    base = nw;
    send(32'h77, 0); send(32'h11, 0); send(32'h22, 1); idle();
    repeat (4) @(negedge clk);
    chk("t3_short", 32'(err_short), 1);
    chk("t3_nw", 32'(nw - base), 5);
    chk("t3_w2", wq[base + 2], 32'h22);
    chk("t3_pad", {wq[base + 3], wq[base + 4]}, 0);
    push_sink(32'h77); push_sink(0); push_sink(5);
    release_core(); wait_valid(); accept(); wait_frames(3);
    @(negedge clk) err_clr = 1'b1;
    @(negedge clk) err_clr = 1'b0;
    chk("t3_clr", 32'(err_short), 0);

    // 4: core declines; err_clr held so the set must still win for one cycle
    op_mode = 1'b1; ref_len = 8; core_accept = 1'b0; load_done = 1'b1;
    base = nw; r0 = nrs; q0 = nrej; err_clr = 1'b1;
    for (int i = 0; i < 8; i++) send(32'h200 + 32'(i), i == 7);
    idle(); repeat (2) @(negedge clk);
    chk("t4_rej_rise", 32'(nrej - q0), 1);
    chk("t4_rej_lat", 32'(rej_cyc - rs_cyc), 4);
    chk("t4_rej_cleared", 32'(err_rej), 0);
    chk("t4_nw", 32'(nw - base), 0);
    chk("t4_rs", 32'(nrs - r0), 1);
    chk("t4_frames", 32'(frames_done), 3);
    chk("t4_idle", 32'(s_tready), 0);
    err_clr = 1'b0; core_accept = 1'b1; load_done = 1'b0;

    // 5: backpressure on src FIFO and on the result port
    op_mode = 1'b0; base = nw; toggle_full = 1'b1;
    send(32'h99, 0); send(5, 0); send(6, 0); send(7, 0); send(8, 1); idle();
    toggle_full = 1'b0; src_fifo_full = 1'b0;
    push_sink(32'h99); push_sink(32'h22); push_sink(32'hFFFF7777);
    release_core(); wait_valid();
    push_sink(32'hAA); push_sink(32'h33); push_sink(32'h12340011);
    repeat (10) @(negedge clk);
    chk("t5_qid", m_qid, 32'h99);
    chk("t5_pos", m_position, 32'h22);
    chk("t5_min", 32'(m_minval), 32'h7777);
    chk("t5_no_read", 32'(sink_fifo_empty), 0);
    accept(); wait_valid();
    chk("t5_qid2", m_qid, 32'hAA);
    chk("t5_min2", 32'(m_minval), 32'h11);
    accept(); wait_frames(4);
    chk("t5_nw", 32'(nw - base), 5);
    chk("t5_w0", wq[base], 32'h99);
    chk("t5_w4", wq[base + 4], 8);
    chk("t5_viol", 32'(viol), 0);

    // 6: reset mid-stream, then a clean frame and an over-long frame
    op_mode = 1'b1; ref_len = 8;
    send(1, 0); send(2, 0); send(3, 0);
    @(negedge clk) rst_n = 1'b0; s_tvalid = 1'b0;
    #1;
    chk("t6_rst_outs", {rs, src_fifo_wren, s_tready, sink_fifo_rden, m_valid, err_short, err_long, err_rej}, 0);
    chk("t6_rst_data", src_fifo_data, 0);
    chk("t6_rst_frames", 32'(frames_done), 0);
    @(negedge clk) rst_n = 1'b1;
    ref_len = 4; base = nw;
    for (int i = 0; i < 4; i++) send(32'hC0 + 32'(i), i == 3);
    idle(); release_core(); wait_frames(1);
    chk("t6_nw", 32'(nw - base), 4);
    chk("t6_w3", wq[base + 3], 32'hC3);
    chk("t6_err", {err_short, err_long, err_rej}, 0);
    base = nw;
    for (int i = 0; i < 6; i++) send(32'hD0 + 32'(i), i == 5);
    idle(); release_core(); wait_frames(2);
    chk("t6_long", {err_short, err_long, err_rej}, 3'b010);
    chk("t6_long_nw", 32'(nw - base), 4);
    chk("t6_viol", 32'(viol), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
